// File: rtl/store_align_pkg.sv
// Shared definitions for the store alignment unit: RISC-V store funct3
// encodings, the beat sequencing state type and store-size decode helpers.
package store_align_pkg;

  localparam logic [2:0] F3_SB = 3'b000;
  localparam logic [2:0] F3_SH = 3'b001;
  localparam logic [2:0] F3_SW = 3'b010;
  localparam logic [2:0] F3_SD = 3'b011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BEAT0 = 2'd1,
    BEAT1 = 2'd2
  } sa_state_e;

  // Store size in bytes; 0 for encodings that are never a store.
  function automatic logic [3:0] f3_size(input logic [2:0] f3);
    logic [3:0] sz;
    case (f3)
      F3_SB:   sz = 4'd1;
      F3_SH:   sz = 4'd2;
      F3_SW:   sz = 4'd4;
      F3_SD:   sz = 4'd8;
      default: sz = 4'd0;
    endcase
    return sz;
  endfunction

  // SD only exists on a 64-bit datapath.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_rv64);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW) ||
           ((f3 == F3_SD) && is_rv64);
  endfunction

endpackage

// File: rtl/store_align_unit_if.sv
// Request and memory-beat bus of the store alignment unit.
// Handshake rule for both channels: a transfer happens on a rising clock edge
// where valid && ready; the source holds its payload stable while valid is
// high and ready is low, and ready may depend combinationally on valid.
// The slave modport is the alignment unit, the master modport is the
// environment (requester plus memory).
interface store_align_unit_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req_valid;
  logic                req_ready;
  logic [ADDR_W-1:0]   req_addr;
  logic [2:0]          req_funct3;
  logic [XLEN-1:0]     req_data;
  logic                mem_valid;
  logic                mem_ready;
  logic [ADDR_W-1:0]   mem_addr;
  logic [XLEN/8-1:0]   mem_we;
  logic [XLEN-1:0]     mem_wdata;
  logic                misalign_err;
  logic                busy;

  modport slave (
    input  req_valid, req_addr, req_funct3, req_data, mem_ready,
    output req_ready, mem_valid, mem_addr, mem_we, mem_wdata, misalign_err, busy
  );

  modport master (
    output req_valid, req_addr, req_funct3, req_data, mem_ready,
    input  req_ready, mem_valid, mem_addr, mem_we, mem_wdata, misalign_err, busy
  );
endinterface

// File: rtl/store_lane_shift.sv
// Combinational lane placement: builds a two-word-wide byte mask and
// shifted data for a store of `size` bytes at byte offset `off`. Bytes outside
// the mask are forced to zero so upper rs2 bits never reach memory.
module store_lane_shift #(
  parameter int XLEN = 32
) (
  input  logic [$clog2(XLEN/8)-1:0] off_i,
  input  logic [3:0]                size_i,
  input  logic [XLEN-1:0]           data_i,
  output logic [2*(XLEN/8)-1:0]     mask_o,
  output logic [2*XLEN-1:0]         data_o
);
  localparam int NB = XLEN / 8;

  logic [15:0]       ones;
  logic [15:0]       mask_wide;
  logic [2*XLEN-1:0] data_wide;

  assign ones      = (16'd1 << size_i) - 16'd1;
  assign mask_wide = ones << off_i;
  assign mask_o    = mask_wide[2*NB-1:0];
  assign data_wide = {{XLEN{1'b0}}, data_i} << {off_i, 3'b000};

  // Zero every byte lane that the mask does not enable.
  always_comb begin
    data_o = '0;
    for (int i = 0; i < 2 * NB; i++) begin
      data_o[8*i +: 8] = data_wide[8*i +: 8] & {8{mask_o[i]}};
    end
  end
endmodule

// File: rtl/store_align_unit.sv
// Store alignment unit: turns a right-justified store request into one or
// two word-aligned memory write beats with byte enables. Word-crossing stores
// are split (MISALIGN_EN=1) or rejected with a one-cycle error pulse.
module store_align_unit
  import store_align_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int ADDR_W      = 32,
  parameter int MISALIGN_EN = 1
) (
  input  logic                clk,
  input  logic                reset,
  store_align_unit_if.slave   bus,
  output sa_state_e           state_dbg_o
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  sa_state_e          state_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [NB-1:0]      we_q;
  logic [XLEN-1:0]    wdata_q;
  logic [NB-1:0]      hi_we_q;
  logic [XLEN-1:0]    hi_data_q;
  logic               cross_q;
  logic               err_q;

  logic [OFF_W-1:0]   off;
  logic [3:0]         size;
  logic [4:0]         end_b;
  logic               crosses;
  logic               req_ok;
  logic [2*NB-1:0]    sh_mask;
  logic [2*XLEN-1:0]  sh_data;
  logic               mem_hs;
  logic               last_beat;
  logic               accept;

  // Request decode: size, offset, word crossing and legality.
  always_comb begin
    off     = bus.req_addr[OFF_W-1:0];
    size    = f3_size(bus.req_funct3);
    end_b   = 5'(off) + 5'(size);
    crosses = end_b > 5'(NB);
    req_ok  = f3_legal(bus.req_funct3, XLEN == 64) &&
              ((MISALIGN_EN != 0) || !crosses);
  end

  store_lane_shift #(.XLEN(XLEN)) u_lane_shift (
    .off_i  (off),
    .size_i (size),
    .data_i (bus.req_data),
    .mask_o (sh_mask),
    .data_o (sh_data)
  );

  // A new request may enter while the final beat of the previous one
  // handshakes, which keeps back-to-back stores bubble-free.
  assign mem_hs        = (state_q != IDLE) && bus.mem_ready;
  assign last_beat     = (state_q == BEAT1) || ((state_q == BEAT0) && !cross_q);
  assign bus.req_ready = (state_q == IDLE) || (mem_hs && last_beat);
  assign accept        = bus.req_valid && bus.req_ready;

  // Beat sequencer: loads both halves on acceptance, steps to the upper half
  // on a crossing store, holds everything while memory stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= '0;
      wdata_q   <= '0;
      hi_we_q   <= '0;
      hi_data_q <= '0;
      cross_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if ((state_q == BEAT0) && mem_hs && cross_q) begin
        state_q <= BEAT1;
        addr_q  <= addr_q + ADDR_W'(NB);
        we_q    <= hi_we_q;
        wdata_q <= hi_data_q;
      end else if (bus.req_ready) begin
        if (accept && req_ok) begin
          state_q   <= BEAT0;
          addr_q    <= {bus.req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          we_q      <= sh_mask[NB-1:0];
          wdata_q   <= sh_data[XLEN-1:0];
          hi_we_q   <= sh_mask[2*NB-1:NB];
          hi_data_q <= sh_data[2*XLEN-1:XLEN];
          cross_q   <= crosses;
        end else begin
          state_q <= IDLE;
          addr_q  <= '0;
          we_q    <= '0;
          wdata_q <= '0;
          err_q   <= accept;
        end
      end
    end
  end

  assign bus.mem_valid    = (state_q != IDLE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.mem_addr     = addr_q;
  assign bus.mem_we       = we_q;
  assign bus.mem_wdata    = wdata_q;
  assign bus.misalign_err = err_q;
  assign state_dbg_o      = state_q;
endmodule

// File: tb/tb_store_align_unit.sv
// Bench for store_align_unit: one instance with misaligned splitting enabled,
// one with it disabled. Directed stores push hand-computed beats into expected
// queues; negedge monitors pop and compare every memory handshake.
module tb_store_align_unit;
  import store_align_pkg::*;

  localparam int W = 68;  // {addr[31:0], we[3:0], wdata[31:0]}

  logic clk = 1'b0;
  logic rst = 1'b1;

  store_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_e ();
  store_align_unit_if #(.XLEN(32), .ADDR_W(32)) bus_d ();
  sa_state_e st_e, st_d;

  store_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(1)) u_en (
    .clk(clk), .reset(rst), .bus(bus_e), .state_dbg_o(st_e));
  store_align_unit #(.XLEN(32), .ADDR_W(32), .MISALIGN_EN(0)) u_dis (
    .clk(clk), .reset(rst), .bus(bus_d), .state_dbg_o(st_d));

  // Clock and cycle counter
  always #5 clk = ~clk;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_qd[$];
  int hs_cyc[$];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_err_e = 0;
  int n_err_d = 0;
  int n_val_d = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_e(input logic [31:0] a, input logic [3:0] we, input logic [31:0] d);
    exp_q.push_back({a, we, d});
  endtask

  // Driver: present a request, wait (bounded) for acceptance, then drop valid.
  task automatic send(input bit dis, input logic [31:0] a, input logic [2:0] f3,
                      input logic [31:0] d);
    int n;
    n = 0;
    if (dis) begin
      bus_d.req_valid = 1'b1; bus_d.req_addr = a; bus_d.req_funct3 = f3; bus_d.req_data = d;
    end else begin
      bus_e.req_valid = 1'b1; bus_e.req_addr = a; bus_e.req_funct3 = f3; bus_e.req_data = d;
    end
    forever begin
      @(negedge clk);
      if (dis ? bus_d.req_ready : bus_e.req_ready) break;
      n++;
      if (n >= 50) begin
        n_tests++; n_fail++;
        $display("FAIL req_timeout: got no req_ready expected acceptance addr %h", a);
        bus_e.req_valid = 1'b0; bus_d.req_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    if (dis) bus_d.req_valid = 1'b0; else bus_e.req_valid = 1'b0;
  endtask

  // Monitor / scoreboard for both instances
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bus_e.misalign_err) n_err_e++;
      if (bus_d.misalign_err) n_err_d++;
      if (bus_d.mem_valid) n_val_d++;
      if (!bus_e.mem_valid) chk("we_idle_e", {64'b0, bus_e.mem_we}, '0);
      if (bus_e.mem_valid && bus_e.mem_ready) begin
        hs_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected_e: got %h expected none",
                   {bus_e.mem_addr, bus_e.mem_we, bus_e.mem_wdata});
        end else chk("beat_e", {bus_e.mem_addr, bus_e.mem_we, bus_e.mem_wdata}, exp_q.pop_front());
      end
      if (bus_d.mem_valid && bus_d.mem_ready) begin
        if (exp_qd.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_unexpected_d: got %h expected none",
                   {bus_d.mem_addr, bus_d.mem_we, bus_d.mem_wdata});
        end else chk("beat_d", {bus_d.mem_addr, bus_d.mem_we, bus_d.mem_wdata}, exp_qd.pop_front());
      end
    end
  end

  initial begin
    int base;
    bus_e.req_valid = 1'b0; bus_e.req_addr = '0; bus_e.req_funct3 = '0; bus_e.req_data = '0;
    bus_e.mem_ready = 1'b1;
    bus_d.req_valid = 1'b0; bus_d.req_addr = '0; bus_d.req_funct3 = '0; bus_d.req_data = '0;
    bus_d.mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready",  {67'b0, bus_e.req_ready}, 68'd1);
    chk("rst_valid",  {67'b0, bus_e.mem_valid}, '0);
    chk("rst_busy",   {67'b0, bus_e.busy}, '0);
    chk("rst_err",    {67'b0, bus_e.misalign_err}, '0);
    chk("rst_outs",   {bus_e.mem_addr, bus_e.mem_we, bus_e.mem_wdata}, '0);
    chk("rst_ready_d", {67'b0, bus_d.req_ready}, 68'd1);

    // Aligned SW, one-cycle latency
    @(posedge clk); #1;
    exp_e(32'h100, 4'b1111, 32'hDEADBEEF);
    send(0, 32'h100, F3_SW, 32'hDEADBEEF);
    @(negedge clk);
    chk("lat_valid", {67'b0, bus_e.mem_valid}, 68'd1);
    @(posedge clk); #1;

    // SB at top byte, SH misaligned inside a word (upper rs2 bits must drop)
    exp_e(32'h100, 4'b1000, 32'hAB000000);
    send(0, 32'h103, F3_SB, 32'h000000AB);
    exp_e(32'h100, 4'b0110, 32'h00CAFE00);
    send(0, 32'h101, F3_SH, 32'hFFFFCAFE);

    // Word-crossing SW split into two beats
    exp_e(32'h100, 4'b1100, 32'h33440000);
    exp_e(32'h104, 4'b0011, 32'h00001122);
    send(0, 32'h102, F3_SW, 32'h11223344);

    // Crossing at the top of the address space wraps to 0
    exp_e(32'hFFFFFFFC, 4'b1100, 32'hC3D40000);
    exp_e(32'h00000000, 4'b0011, 32'h0000A1B2);
    send(0, 32'hFFFFFFFE, F3_SW, 32'hA1B2C3D4);
    repeat (3) @(posedge clk); #1;

    // Stall 3 cycles in BEAT0, then back-to-back SWs
    bus_e.mem_ready = 1'b0;
    exp_e(32'h200, 4'b1111, 32'h55667788);
    send(0, 32'h200, F3_SW, 32'h55667788);
    base = hs_cyc.size();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_beat",  {bus_e.mem_addr, bus_e.mem_we, bus_e.mem_wdata},
                         {32'h200, 4'b1111, 32'h55667788});
      chk("stall_valid", {67'b0, bus_e.mem_valid}, 68'd1);
      chk("stall_ready", {67'b0, bus_e.req_ready}, '0);
    end
    @(posedge clk); #1;
    bus_e.mem_ready = 1'b1;
    exp_e(32'h204, 4'b1111, 32'h01010101);
    send(0, 32'h204, F3_SW, 32'h01010101);
    exp_e(32'h208, 4'b1111, 32'h02020202);
    send(0, 32'h208, F3_SW, 32'h02020202);
    exp_e(32'h20C, 4'b1111, 32'h03030303);
    send(0, 32'h20C, F3_SW, 32'h03030303);
    repeat (2) @(negedge clk);
    chk("b2b_count", 68'(hs_cyc.size() - base), 68'd4);
    if (hs_cyc.size() - base == 4)
      for (int i = base + 1; i < base + 4; i++)
        chk("b2b_gap", 68'(hs_cyc[i] - hs_cyc[i-1]), 68'd1);
    @(posedge clk); #1;

    // Illegal funct3 (1xx and SD on 32-bit) -> error pulse, no beat
    send(0, 32'h500, 3'b100, 32'h12345678);
    @(negedge clk);
    chk("ill_err",   {67'b0, bus_e.misalign_err}, 68'd1);
    chk("ill_valid", {67'b0, bus_e.mem_valid}, '0);
    @(posedge clk); #1;
    send(0, 32'h508, F3_SD, 32'h12345678);
    repeat (2) @(posedge clk); #1;

    // Reset while in BEAT1 abandons the second beat
    bus_e.mem_ready = 1'b0;
    exp_e(32'h300, 4'b1100, 32'hBBCC0000);
    send(0, 32'h302, F3_SW, 32'h99AABBCC);
    bus_e.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus_e.mem_ready = 1'b0;
    @(negedge clk);
    chk("b1_beat", {bus_e.mem_addr, 4'b0, 32'b0, bus_e.mem_valid},
                   {32'h304, 4'b0, 32'b0, 1'b1});
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rb_valid", {67'b0, bus_e.mem_valid}, '0);
    chk("rb_busy",  {67'b0, bus_e.busy}, '0);
    chk("rb_ready", {67'b0, bus_e.req_ready}, 68'd1);
    @(posedge clk); #1;
    bus_e.mem_ready = 1'b1;
    exp_e(32'h400, 4'b1111, 32'h0BADF00D);
    send(0, 32'h400, F3_SW, 32'h0BADF00D);

    // MISALIGN_EN=0: crossing SH rejected, aligned SW still works
    send(1, 32'h103, F3_SH, 32'h00001234);
    @(negedge clk);
    chk("dis_err",   {67'b0, bus_d.misalign_err}, 68'd1);
    chk("dis_valid", {67'b0, bus_d.mem_valid}, '0);
    @(negedge clk);
    chk("dis_err_pulse", {67'b0, bus_d.misalign_err}, '0);
    @(posedge clk); #1;
    exp_qd.push_back({32'h100, 4'b1111, 32'hDEADBEEF});
    send(1, 32'h100, F3_SW, 32'hDEADBEEF);

    // Drain and final tallies
    for (int i = 0; i < 20 && (exp_q.size() != 0 || exp_qd.size() != 0); i++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("drain_e", 68'(exp_q.size()), '0);
    chk("drain_d", 68'(exp_qd.size()), '0);
    chk("errs_e",  68'(n_err_e), 68'd2);
    chk("errs_d",  68'(n_err_d), 68'd1);
    chk("valid_d", 68'(n_val_d), 68'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
